// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into instruction memory,
// optionally reads them back to compare checksums, then enables the CPU.
module imem_loader #(
    parameter int MAX_WORDS = 512,
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start,
    input  logic             stop,
    input  logic             verify_en,
    input  logic [63:0]      base_addr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] word_count,
    output logic [31:0]      checksum
);

    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DRAIN, RUN, ERR} state_t;

    state_t            state, state_nxt;
    logic [63:0]       base_q;
    logic              verify_q;
    logic [CNT_W-1:0]  rd_idx;
    logic [31:0]       rb_sum;
    logic [RD_LAT-1:0] vld_pipe;
    logic              start_ok, accept, ovf, issue, drain_fail;
    logic [63:0]       wr_off, rd_off;

    assign wr_off  = 64'(word_count) << 2;
    assign rd_off  = 64'(rd_idx) << 2;
    assign s_ready = (state == LOAD);
    assign busy    = (state == LOAD) || (state == VERIFY) || (state == DRAIN);

    // State register
    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and per-cycle action strobes
    always_comb begin
        state_nxt  = state;
        start_ok   = 1'b0;
        accept     = 1'b0;
        ovf        = 1'b0;
        issue      = 1'b0;
        drain_fail = 1'b0;
        case (state)
            IDLE, ERR: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    accept = 1'b1;
                    // A word beyond capacity is swallowed, not written
                    if (word_count == CNT_W'(MAX_WORDS)) begin
                        ovf       = 1'b1;
                        state_nxt = ERR;
                    end else if (s_last) begin
                        state_nxt = verify_q ? VERIFY : RUN;
                    end
                end
            end
            VERIFY: begin
                issue = 1'b1;
                if (rd_idx == word_count - CNT_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Last read still on the bus or in the return pipe: keep waiting
                if (!ren_ext && (vld_pipe == '0)) begin
                    if (rb_sum == checksum) begin
                        state_nxt = RUN;
                    end else begin
                        drain_fail = 1'b1;
                        state_nxt  = ERR;
                    end
                end
            end
            RUN: begin
                if (stop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: registered memory port, counters, sums and status flags
    always_ff @(posedge clk) begin
        if (srst) begin
            base_q     <= '0;
            verify_q   <= 1'b0;
            addr_ext   <= '0;
            wen_ext    <= 1'b0;
            ren_ext    <= 1'b0;
            wdata_ext  <= '0;
            cpu_enable <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
            rd_idx     <= '0;
            rb_sum     <= '0;
            vld_pipe   <= '0;
        end else begin
            wen_ext    <= 1'b0;
            ren_ext    <= 1'b0;
            cpu_enable <= (state_nxt == RUN);
            done       <= (state_nxt == RUN) && (state != RUN);

            vld_pipe[0] <= ren_ext;
            for (int k = 1; k < RD_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];

            if (start_ok) begin
                base_q     <= base_addr;
                verify_q   <= verify_en;
                addr_ext   <= base_addr;
                word_count <= '0;
                checksum   <= '0;
                error      <= 1'b0;
                rd_idx     <= '0;
                rb_sum     <= '0;
            end

            if (accept && !ovf) begin
                wen_ext    <= 1'b1;
                addr_ext   <= base_q + wr_off;
                wdata_ext  <= s_data;
                word_count <= word_count + CNT_W'(1);
                checksum   <= checksum + s_data;
            end

            if (issue) begin
                ren_ext  <= 1'b1;
                addr_ext <= base_q + rd_off;
                rd_idx   <= rd_idx + CNT_W'(1);
            end

            // Oldest tag marks the cycle its read data is on rdata_ext
            if (vld_pipe[RD_LAT-1]) rb_sum <= rb_sum + rdata_ext;

            if (ovf || drain_fail) error <= 1'b1;
        end
    end

endmodule
